// File: rtl/branch_resolution_unit_if.sv
// Bundle between IF/BTB, the EX comparator and the branch resolution unit.
// The slave modport is the resolution unit's view; the master is everything around it.
interface branch_resolution_unit_if #(
  parameter int CNT_W = 32
);
  logic             if_valid;
  logic [31:0]      if_pc;
  logic             btb_valid;
  logic             btb_predicted_taken;
  logic [31:0]      btb_target_pc;
  logic             stall;
  logic             ex_is_branch;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             update;
  logic [31:0]      update_pc;
  logic [31:0]      update_target;
  logic             mispredicted;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport slave (
    input  if_valid, if_pc, btb_valid, btb_predicted_taken, btb_target_pc,
           stall, ex_is_branch, ex_taken, ex_target,
    output redirect, redirect_pc, flush, update, update_pc, update_target,
           mispredicted, branch_count, mispredict_count
  );

  modport master (
    output if_valid, if_pc, btb_valid, btb_predicted_taken, btb_target_pc,
           stall, ex_is_branch, ex_taken, ex_target,
    input  redirect, redirect_pc, flush, update, update_pc, update_target,
           mispredicted, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolution_unit.sv
// Carries BTB predictions through IF/ID and ID/EX, checks them against the EX
// outcome, redirects/flushes fetch on a mispredict and trains the BTB one edge later.
module branch_resolution_unit #(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  branch_resolution_unit_if.slave bus
);

  logic             s1_v_q, s1_v_d;
  logic [31:0]      s1_pc_q, s1_pc_d;
  logic             s1_pt_q, s1_pt_d;
  logic [31:0]      s1_tgt_q, s1_tgt_d;
  logic             s2_v_q, s2_v_d;
  logic [31:0]      s2_pc_q, s2_pc_d;
  logic             s2_pt_q, s2_pt_d;
  logic [31:0]      s2_tgt_q, s2_tgt_d;

  logic             update_q, update_d;
  logic [31:0]      update_pc_q, update_pc_d;
  logic [31:0]      update_target_q, update_target_d;
  logic             mispredicted_q, mispredicted_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic             active;
  logic             mispredict;
  logic             flush_c;
  logic             resolve_branch;
  logic [31:0]      pc_plus4;
  logic [31:0]      fix_pc;

  // Resolution of the instruction sitting in EX; a stalled EX never resolves.
  always_comb begin
    pc_plus4   = s2_pc_q + 32'd4;
    active     = s2_v_q & ~bus.stall;
    mispredict = 1'b0;
    fix_pc     = pc_plus4;
    if (bus.ex_is_branch) begin
      if (s2_pt_q && !bus.ex_taken) begin
        mispredict = 1'b1;
        fix_pc     = pc_plus4;
      end else if (!s2_pt_q && bus.ex_taken) begin
        mispredict = 1'b1;
        fix_pc     = bus.ex_target;
      end else if (s2_pt_q && bus.ex_taken && (s2_tgt_q != bus.ex_target)) begin
        mispredict = 1'b1;
        fix_pc     = bus.ex_target;
      end
    end else if (s2_pt_q) begin
      mispredict = 1'b1;
      fix_pc     = pc_plus4;
    end
    flush_c        = active & mispredict;
    resolve_branch = active & bus.ex_is_branch;
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_pc_d  = s1_pc_q;
    s1_pt_d  = s1_pt_q;
    s1_tgt_d = s1_tgt_q;
    s2_v_d   = s2_v_q;
    s2_pc_d  = s2_pc_q;
    s2_pt_d  = s2_pt_q;
    s2_tgt_d = s2_tgt_q;
    if (flush_c) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else if (!bus.stall) begin
      s1_v_d   = bus.if_valid;
      s1_pc_d  = bus.if_pc;
      s1_pt_d  = bus.btb_valid & bus.btb_predicted_taken;
      s1_tgt_d = bus.btb_valid ? bus.btb_target_pc : 32'd0;
      s2_v_d   = s1_v_q;
      s2_pc_d  = s1_pc_q;
      s2_pt_d  = s1_pt_q;
      s2_tgt_d = s1_tgt_q;
    end
  end

  // BTB training and counters; alias mispredicts count but never write the BTB.
  always_comb begin
    update_d           = resolve_branch;
    update_pc_d        = update_pc_q;
    update_target_d    = update_target_q;
    mispredicted_d     = mispredicted_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve_branch) begin
      update_pc_d     = s2_pc_q;
      update_target_d = bus.ex_target;
      mispredicted_d  = mispredict;
      if (branch_count_q != {CNT_W{1'b1}})
        branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (flush_c && (mispredict_count_q != {CNT_W{1'b1}}))
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q             <= 1'b0;
      s1_pc_q            <= 32'd0;
      s1_pt_q            <= 1'b0;
      s1_tgt_q           <= 32'd0;
      s2_v_q             <= 1'b0;
      s2_pc_q            <= 32'd0;
      s2_pt_q            <= 1'b0;
      s2_tgt_q           <= 32'd0;
      update_q           <= 1'b0;
      update_pc_q        <= 32'd0;
      update_target_q    <= 32'd0;
      mispredicted_q     <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      s1_v_q             <= s1_v_d;
      s1_pc_q            <= s1_pc_d;
      s1_pt_q            <= s1_pt_d;
      s1_tgt_q           <= s1_tgt_d;
      s2_v_q             <= s2_v_d;
      s2_pc_q            <= s2_pc_d;
      s2_pt_q            <= s2_pt_d;
      s2_tgt_q           <= s2_tgt_d;
      update_q           <= update_d;
      update_pc_q        <= update_pc_d;
      update_target_q    <= update_target_d;
      mispredicted_q     <= mispredicted_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.redirect         = flush_c;
  assign bus.redirect_pc      = flush_c ? fix_pc : 32'd0;
  assign bus.flush            = flush_c;
  assign bus.update           = update_q;
  assign bus.update_pc        = update_pc_q;
  assign bus.update_target    = update_target_q;
  assign bus.mispredicted     = mispredicted_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed and random checks of branch_resolution_unit against an instruction-level model.
module tb_branch_resolution_unit;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  branch_resolution_unit_if #(.CNT_W(CW)) bus ();
  branch_resolution_unit #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } meta_t;

  meta_t          m_ifid, m_idex;
  logic           m_upd, m_mis;
  logic [31:0]    m_upd_pc, m_upd_tgt;
  logic [CW-1:0]  m_bc, m_mc;
  logic [CW-1:0]  bc_snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ifid = '0; m_idex = '0;
    m_upd = 0; m_mis = 0; m_upd_pc = 0; m_upd_tgt = 0; m_bc = 0; m_mc = 0;
  endtask

  // What EX should conclude about the instruction the model holds in ID/EX.
  task automatic m_resolve(output logic act, output logic mis, output logic [31:0] fix);
    act = m_idex.v && !bus.stall;
    mis = 0;
    fix = 32'd0;
    if (bus.ex_is_branch) begin
      if (m_idex.pt && !bus.ex_taken) begin mis = 1; fix = m_idex.pc + 32'd4; end
      else if (!m_idex.pt && bus.ex_taken) begin mis = 1; fix = bus.ex_target; end
      else if (m_idex.pt && bus.ex_taken && m_idex.tgt != bus.ex_target) begin
        mis = 1; fix = bus.ex_target;
      end
    end else if (m_idex.pt) begin
      mis = 1; fix = m_idex.pc + 32'd4;
    end
  endtask

  task automatic tick();
    logic act, mis;
    logic [31:0] fix;
    #1;
    m_resolve(act, mis, fix);
    chk("redirect", bus.redirect, act && mis);
    chk("flush", bus.flush, act && mis);
    if (act && mis) chk("redirect_pc", bus.redirect_pc, fix);
    @(posedge clk);
    #1;
    if (act && bus.ex_is_branch) begin
      m_upd = 1; m_upd_pc = m_idex.pc; m_upd_tgt = bus.ex_target; m_mis = mis;
      if (m_bc != CMAX) m_bc++;
    end else m_upd = 0;
    if (act && mis && m_mc != CMAX) m_mc++;
    if (act && mis) begin
      m_ifid.v = 0; m_idex.v = 0;
    end else if (!bus.stall) begin
      m_idex = m_ifid;
      m_ifid = '{v: bus.if_valid, pc: bus.if_pc,
                 pt: bus.btb_valid && bus.btb_predicted_taken,
                 tgt: bus.btb_valid ? bus.btb_target_pc : 32'd0};
    end
    chk("update", bus.update, m_upd);
    chk("update_pc", bus.update_pc, m_upd_pc);
    chk("update_target", bus.update_target, m_upd_tgt);
    chk("mispredicted", bus.mispredicted, m_mis);
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
  endtask

  task automatic idle();
    bus.if_valid = 0; bus.if_pc = 0; bus.btb_valid = 0; bus.btb_predicted_taken = 0;
    bus.btb_target_pc = 0; bus.stall = 0; bus.ex_is_branch = 0; bus.ex_taken = 0;
    bus.ex_target = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    bus.if_valid = 1; bus.if_pc = pc; bus.btb_valid = hit;
    bus.btb_predicted_taken = tk; bus.btb_target_pc = tgt;
  endtask

  task automatic ex(input logic br, input logic tk, input logic [31:0] tgt);
    bus.ex_is_branch = br; bus.ex_taken = tk; bus.ex_target = tgt;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_redirect"}, bus.redirect, 0);
    chk({tag, "_flush"}, bus.flush, 0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 0);
    chk({tag, "_update"}, bus.update, 0);
    chk({tag, "_update_pc"}, bus.update_pc, 0);
    chk({tag, "_update_target"}, bus.update_target, 0);
    chk({tag, "_mispredicted"}, bus.mispredicted, 0);
    chk({tag, "_branch_count"}, bus.branch_count, 0);
    chk({tag, "_mispredict_count"}, bus.mispredict_count, 0);
  endtask

  initial begin
    idle();
    m_reset();
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 0;

    // predicted taken, correct
    fetch(32'h000A0000, 1, 1, 32'h000A0020); tick();
    idle(); tick();
    ex(1, 1, 32'h000A0020); tick();
    chk("t1_update", bus.update, 1);
    chk("t1_mispredicted", bus.mispredicted, 0);
    chk("t1_update_pc", bus.update_pc, 32'h000A0000);
    chk("t1_branch_count", bus.branch_count, 1);

    // taken but not predicted
    idle(); fetch(32'h000B0000, 0, 0, 32'h0); tick();
    idle(); tick();
    ex(1, 1, 32'h000B0020);
    #1;
    chk("t2_redirect", bus.redirect, 1);
    chk("t2_flush", bus.flush, 1);
    chk("t2_redirect_pc", bus.redirect_pc, 32'h000B0020);
    tick();
    chk("t2_update", bus.update, 1);
    chk("t2_mispredicted", bus.mispredicted, 1);
    chk("t2_mispredict_count", bus.mispredict_count, 1);

    // predicted taken, actually not taken
    idle(); fetch(32'h000A0000, 1, 1, 32'h000A0020); tick();
    idle(); tick();
    ex(1, 0, 32'h000A0004);
    #1;
    chk("t3_redirect_pc", bus.redirect_pc, 32'h000A0004);
    tick();
    chk("t3_mispredicted", bus.mispredicted, 1);

    // stall in EX for 3 cycles
    idle(); fetch(32'h000C0000, 1, 1, 32'h000C0040); tick();
    idle(); tick();
    bc_snap = bus.branch_count;
    ex(1, 1, 32'h000C0080);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_redirect", bus.redirect, 0);
      tick();
      chk("t4_stall_update", bus.update, 0);
    end
    bus.stall = 0;
    tick();
    chk("t4_release_update", bus.update, 1);
    chk("t4_branch_count", bus.branch_count, bc_snap + 1'b1);
    idle(); tick();
    chk("t4_single_update", bus.update, 0);
    chk("t4_branch_count_hold", bus.branch_count, bc_snap + 1'b1);

    // alias plus flush
    fetch(32'h00000100, 1, 1, 32'h00000200); tick();
    fetch(32'h00000104, 0, 0, 32'h0); tick();
    fetch(32'h00000108, 0, 0, 32'h0);
    ex(0, 0, 32'h0);
    #1;
    chk("t5_redirect", bus.redirect, 1);
    chk("t5_redirect_pc", bus.redirect_pc, 32'h00000104);
    tick();
    chk("t5_no_update", bus.update, 0);
    idle(); ex(1, 1, 32'h00000999);
    #1;
    chk("t5_younger_dropped", bus.redirect, 0);
    tick();
    chk("t5_no_update_after", bus.update, 0);
    idle(); tick();
    chk("t5_fetch_in_flush_dropped", bus.update, 0);

    // pc+4 wraps
    fetch(32'hFFFFFFFC, 1, 1, 32'h00000040); tick();
    idle(); tick();
    ex(1, 0, 32'h0);
    #1;
    chk("t6_wrap_redirect_pc", bus.redirect_pc, 32'h00000000);
    tick();

    // async reset between resolution and the update edge
    idle(); fetch(32'h000D0000, 0, 0, 32'h0); tick();
    idle(); tick();
    ex(1, 1, 32'h000D0100);
    #1;
    chk("t7_redirect_before_reset", bus.redirect, 1);
    #1;
    rst = 1;
    m_reset();
    #1;
    chk_reset_outputs("t7_async");
    @(posedge clk); #1;
    chk_reset_outputs("t7_held");
    rst = 0;
    idle();
    tick();
    chk("t7_no_pending_update", bus.update, 0);

    // random traffic against the model
    for (int n = 0; n < 700; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {$urandom_range(0, 255), 2'b00};
      bus.if_valid            = ($urandom_range(0, 3) != 0);
      bus.if_pc               = pc;
      bus.btb_valid           = $urandom_range(0, 1);
      bus.btb_predicted_taken = $urandom_range(0, 1);
      bus.btb_target_pc       = {$urandom_range(0, 7), 4'h0};
      bus.stall               = ($urandom_range(0, 3) == 0);
      bus.ex_is_branch        = ($urandom_range(0, 3) != 0);
      bus.ex_taken            = $urandom_range(0, 1);
      bus.ex_target           = $urandom_range(0, 1) ? m_idex.tgt : {$urandom_range(0, 7), 4'h0};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
